coherent_bus_arbiter: RTL

Parametrised successor to the two-cache snooping bus controller: arbitrates NCACHE data caches plus one instruction cache onto a single memory port and moves multi-word blocks with MSI-style snooping. Replaces the fixed two-cache, two-word state sequence with an N-cache controller that supports arbitrary block length and round-robin fairness. Sits between the per-core L1 caches and the RAM/memory-control interface.

---
 rtl/coherent_bus_arbiter.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/coherent_bus_arbiter.sv
// N-cache MSI snooping bus arbiter: grants dcaches (then the icache) onto one memory port and moves WORDS-word blocks.
// Define COHERENT_BUS_RR_ARB_EN for round-robin dcache arbitration; otherwise the lowest index wins.
module coherent_bus_arbiter #(
   parameter int NCACHE = 2,
   parameter int WORDS  = 2
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [NCACHE-1:0]    dREN,
   input  logic [NCACHE-1:0]    dWEN,
   input  logic [32*NCACHE-1:0] daddr,
   input  logic [32*NCACHE-1:0] dstore,
   input  logic [NCACHE-1:0]    cctrans,
   input  logic [NCACHE-1:0]    ccwrite,
   input  logic [NCACHE-1:0]    snoop_hit,
   input  logic [NCACHE-1:0]    snoop_dirty,
   output logic [NCACHE-1:0]    dwait,
   output logic [31:0]          dload,
   output logic [NCACHE-1:0]    ccwait,
   output logic [NCACHE-1:0]    ccinv,
   output logic [31:0]          ccsnoopaddr,
   input  logic                 iREN,
   input  logic [31:0]          iaddr,
   output logic                 iwait,
   output logic [31:0]          iload,
   output logic                 ramREN,
   output logic                 ramWEN,
   output logic [31:0]          ramaddr,
   output logic [31:0]          ramstore,
   input  logic [31:0]          ramload,
   input  logic                 ramrdy
);

   localparam int GW = $clog2(NCACHE);
   localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [31:0]   BLOCK_MASK = 32'(WORDS * 4 - 1);
   localparam logic [KW-1:0] LAST_WORD  = KW'(WORDS - 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] ICACHE = 3'd1;
   localparam logic [2:0] SNOOP  = 3'd2;
   localparam logic [2:0] FLUSH  = 3'd3;
   localparam logic [2:0] WB     = 3'd4;
   localparam logic [2:0] LD     = 3'd5;

   logic [2:0]        state;
   logic [GW-1:0]     grant;
   logic [GW-1:0]     snooper;
   logic [GW-1:0]     pick;
   logic [GW-1:0]     dirty_pick;
   logic              found;
   logic              dirty_found;
   logic [KW-1:0]     word;
   logic              last_word;
   logic [NCACHE-1:0] req;
   logic [NCACHE-1:0] grant_mask;
   logic [NCACHE-1:0] dirty_others;
   logic [31:0]       daddr_lane [NCACHE];
   logic [31:0]       dstore_lane [NCACHE];
   logic [31:0]       grant_addr;
   logic [31:0]       word_addr;
   logic              unused_snoop_hit;

   for (genvar i = 0; i < NCACHE; i++) begin : g_lane
      assign daddr_lane[i]  = daddr[32*i +: 32];
      assign dstore_lane[i] = dstore[32*i +: 32];
   end

   assign req              = dREN | dWEN;
   assign grant_mask       = {{(NCACHE-1){1'b0}}, 1'b1} << grant;
   assign dirty_others     = snoop_dirty & ~grant_mask;
   assign grant_addr       = daddr_lane[grant];
   assign word_addr        = (grant_addr & ~BLOCK_MASK) | (32'(word) << 2);
   assign last_word        = (word == LAST_WORD);
   assign dload            = ramload;
   assign iload            = ramload;
   assign unused_snoop_hit = ^snoop_hit;

   // The requester's own snoop response is meaningless, so only other caches can supply dirty data.
   always_comb begin
      dirty_pick  = '0;
      dirty_found = 1'b0;
      for (int i = 0; i < NCACHE; i++) begin
         if (!dirty_found && dirty_others[i]) begin
            dirty_pick  = GW'(i);
            dirty_found = 1'b1;
         end
      end
   end

`ifdef COHERENT_BUS_RR_ARB_EN
   logic [GW-1:0] rr_ptr;
   logic [GW:0]   rr_sum;
   logic [GW-1:0] rr_idx;

   always_comb begin
      pick   = '0;
      found  = 1'b0;
      rr_sum = '0;
      rr_idx = '0;
      for (int i = 0; i < NCACHE; i++) begin
         rr_sum = {1'b0, rr_ptr} + (GW+1)'(i);
         if (rr_sum >= (GW+1)'(NCACHE))
            rr_sum = rr_sum - (GW+1)'(NCACHE);
         rr_idx = rr_sum[GW-1:0];
         if (!found && req[rr_idx]) begin
            pick  = rr_idx;
            found = 1'b1;
         end
      end
   end

   // Pointer moves past the cache whose block just finished, so the next search starts after it.
   always_ff @(posedge CLK) begin
      if (RST)
         rr_ptr <= '0;
      else if ((state == WB || state == LD) && ramrdy && last_word)
         rr_ptr <= (grant == GW'(NCACHE - 1)) ? '0 : grant + 1'b1;
   end
`else
   always_comb begin
      pick  = '0;
      found = 1'b0;
      for (int i = 0; i < NCACHE; i++) begin
         if (!found && req[i]) begin
            pick  = GW'(i);
            found = 1'b1;
         end
      end
   end
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         grant   <= '0;
         snooper <= '0;
         word    <= '0;
      end else begin
         case (state)
            IDLE: begin
               word <= '0;
               if (found) begin
                  grant <= pick;
                  if (dWEN[pick])
                     state <= WB;
                  else if (cctrans[pick])
                     state <= SNOOP;
                  else
                     state <= LD;
               end else if (iREN) begin
                  state <= ICACHE;
               end
            end
            ICACHE: if (ramrdy) state <= IDLE;
            SNOOP: begin
               if (dirty_found) begin
                  snooper <= dirty_pick;
                  state   <= FLUSH;
               end else begin
                  state <= LD;
               end
            end
            FLUSH: begin
               if (ramrdy) begin
                  if (last_word) begin
                     word  <= '0;
                     state <= LD;
                  end else begin
                     word <= word + 1'b1;
                  end
               end
            end
            WB, LD: begin
               if (ramrdy) begin
                  if (last_word) begin
                     word  <= '0;
                     state <= IDLE;
                  end else begin
                     word <= word + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Strobes decode straight from the registered state; only the wait pulses follow ramrdy.
   always_comb begin
      dwait       = '1;
      iwait       = 1'b1;
      ramREN      = 1'b0;
      ramWEN      = 1'b0;
      ramaddr     = '0;
      ramstore    = '0;
      ccsnoopaddr = '0;
      ccwait      = '0;
      ccinv       = '0;
      case (state)
         ICACHE: begin
            ramREN  = 1'b1;
            ramaddr = iaddr;
            iwait   = ~ramrdy;
         end
         SNOOP: begin
            ccwait      = ~grant_mask;
            ccsnoopaddr = grant_addr;
            if (ccwrite[grant])
               ccinv = ~grant_mask;
         end
         FLUSH: begin
            ramWEN      = 1'b1;
            ramaddr     = word_addr;
            ramstore    = dstore_lane[snooper];
            ccsnoopaddr = word_addr;
            ccwait      = ~grant_mask;
         end
         WB: begin
            ramWEN   = 1'b1;
            ramaddr  = word_addr;
            ramstore = dstore_lane[grant];
            if (ramrdy)
               dwait = ~grant_mask;
         end
         LD: begin
            ramREN  = 1'b1;
            ramaddr = word_addr;
            if (ramrdy)
               dwait = ~grant_mask;
         end
         default: ;
      endcase
   end

endmodule
